line_raster_unit: RTL
=====================

Name: line_raster_unit

Overview:
- Downstream neighbour of clipping_unit in the VPU pipeline.
- Accepts one clipped line segment at a time over a valid/ready handshake; raster_ready is the handshake signal clipping_unit already consumes.
- Rasterizes each segment with integer Bresenham, one pixel per cycle.
- Emits framebuffer write requests (linear address, 8-bit colour) into video memory.

Parameters:
SCREEN_W, 640, horizontal resolution in pixels
SCREEN_H, 480, vertical resolution in pixels
XW, 10, x coordinate width
YW, 9, y coordinate width
AW, 19, framebuffer address width

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
seg_vld  input  1  clipper presents a segment
seg_x0  input  XW  start x
seg_y0  input  YW  start y
seg_x1  input  XW  end x
seg_y1  input  YW  end y
seg_color  input  8  segment colour
raster_ready  output  1  unit can accept a segment
fb_busy  input  1  framebuffer cannot accept a write this cycle
fb_wr_en  output  1  pixel write request
fb_addr  output  AW  pixel address, y*SCREEN_W + x
fb_data  output  8  pixel colour
seg_done  output  1  one-cycle pulse: segment fully written
oob_flag  output  1  sticky: a pixel outside the screen was suppressed; cleared only by rst

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
  - Reset values: raster_ready=1, fb_wr_en=0, fb_addr=0, fb_data=0, seg_done=0, oob_flag=0, state=IDLE.
  - rst asserted mid-segment aborts the segment immediately: no further writes, no seg_done.
- IDLE:
  - raster_ready=1.
  - On seg_vld & raster_ready, latch all seg_* inputs and go to SETUP. raster_ready drops the next cycle.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=|y1-y0| in XW+1 bits.
  - sx=+1 if x1>=x0 else -1; sy likewise.
  - err = dx - dy, signed XW+2 bits.
  - cur=(x0,y0). Go to DRAW.
- DRAW: each cycle with fb_busy=0:
  - Present cur: fb_wr_en=1, fb_addr=(cur_y<<9)+(cur_y<<7)+cur_x for the default SCREEN_W (general: cur_y*SCREEN_W+cur_x), fb_data=latched colour.
  - If cur==(x1,y1): go to DONE.
  - Else e2=2*err:
    - if e2 > -dy: err -= dy, cur_x += sx;
    - if e2 < dx: err += dx, cur_y += sy;
    - both updates may apply in the same cycle.
- Stall: when fb_busy=1, fb_wr_en, fb_addr and fb_data hold their values and no stepping occurs. A write is counted only in a cycle with fb_wr_en=1 and fb_busy=0.
- Out-of-screen pixel (cur_x>=SCREEN_W or cur_y>=SCREEN_H):
  - fb_wr_en=0 that cycle; oob_flag set.
  - Stepping continues; fb_busy is ignored for that cycle.
- DONE (1 cycle): seg_done=1, fb_wr_en=0, then IDLE. raster_ready returns to 1 in the cycle after DONE.
- Latency and throughput:
  - Handshake at cycle N; first write presented at N+2.
  - Pixel count = max(dx,dy)+1.
  - With no stalls, seg_done is asserted at cycle N+2+count.
- seg_vld while raster_ready=0 is ignored; the clipper holds its segment.
- Degenerate segment (x0==x1, y0==y1): exactly one write, then DONE.
- Coordinates are unsigned. No wrap-around: stepping terminates exactly on the endpoint.

Test Plan:
- Horizontal (0,0)->(3,0), colour 0x1F, fb_busy=0 -> fb_addr 0,1,2,3 on consecutive cycles starting 2 cycles after handshake; fb_data=0x1F throughout; seg_done on the cycle after the 4th write; raster_ready high the cycle after that.
- Vertical (5,2)->(5,4) -> addresses 1285, 1925, 2565; exactly 3 writes.
- Reversed diagonal (3,3)->(0,0) -> addresses 1923, 1282, 641, 0. Shallow (0,0)->(4,2) -> pixels (0,0),(1,0)/(1,1) per Bresenham,(2,1),(3,1)/(3,2),(4,2); 5 writes; compare against a reference model.
- Stall: fb_busy=1 for 3 cycles during the 2nd pixel of (0,0)->(3,0) -> address 1 held stable for 4 cycles; total writes still 4; seg_done delayed by 3 cycles.
- Single point (639,479) -> one write at address 307199. Segment (638,0)->(641,0) (XW allows it) -> writes at 638 and 639 only; oob_flag=1; seg_done still asserted.
- rst asserted during the 2nd pixel of a 10-pixel segment -> next cycle fb_wr_en=0, raster_ready=1, no seg_done; a new segment accepted afterwards renders correctly.

Source files
------------

// File: rtl/line_raster_unit.sv
// Bresenham line rasterizer: takes one clipped segment over a valid/ready
// handshake and emits one framebuffer write per cycle, stalling on fb_busy.
module line_raster_unit #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 9,
    parameter int unsigned AW       = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          seg_vld,
    input  logic [XW-1:0] seg_x0,
    input  logic [YW-1:0] seg_y0,
    input  logic [XW-1:0] seg_x1,
    input  logic [YW-1:0] seg_y1,
    input  logic [7:0]    seg_color,
    output logic          raster_ready,
    input  logic          fb_busy,
    output logic          fb_wr_en,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic          seg_done,
    output logic          oob_flag
);

    localparam int unsigned DW  = XW + 1;
    localparam int unsigned EW  = XW + 2;
    localparam int unsigned E2W = XW + 3;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t               state;
    logic [XW-1:0]        cur_x, x1_q;
    logic [YW-1:0]        cur_y, y1_q;
    logic [7:0]           color_q;
    logic [DW-1:0]        dx, dy;
    logic                 sx_neg, sy_neg;
    logic signed [EW-1:0] err;

    logic [DW-1:0]         dx_c, dy_c;
    logic signed [E2W-1:0] e2_c, ndy_c, pdx_c;
    logic                  step_x_c, step_y_c, at_end_c, advance_c, in_scr_c;
    logic signed [EW-1:0]  nerr_c;
    logic [XW-1:0]         nx_c, pix_x_c;
    logic [YW-1:0]         ny_c, pix_y_c;
    logic [AW-1:0]         pix_addr_c;

    // Bresenham step and the address of the pixel to be presented next
    always_comb begin
        dx_c     = (x1_q >= cur_x) ? DW'(x1_q - cur_x) : DW'(cur_x - x1_q);
        dy_c     = (y1_q >= cur_y) ? DW'(y1_q - cur_y) : DW'(cur_y - y1_q);
        e2_c     = $signed({err, 1'b0});
        ndy_c    = -$signed(E2W'(dy));
        pdx_c    = $signed(E2W'(dx));
        step_x_c = e2_c > ndy_c;
        step_y_c = e2_c < pdx_c;
        nerr_c   = err;
        nx_c     = cur_x;
        ny_c     = cur_y;
        if (step_x_c) begin
            nerr_c = nerr_c - $signed(EW'(dy));
            nx_c   = sx_neg ? cur_x - XW'(1) : cur_x + XW'(1);
        end
        if (step_y_c) begin
            nerr_c = nerr_c + $signed(EW'(dx));
            ny_c   = sy_neg ? cur_y - YW'(1) : cur_y + YW'(1);
        end
        at_end_c   = (cur_x == x1_q) && (cur_y == y1_q);
        // an off-screen pixel is skipped regardless of fb_busy
        advance_c  = (state == DRAW) && (!fb_wr_en || !fb_busy);
        pix_x_c    = (state == DRAW) ? nx_c : cur_x;
        pix_y_c    = (state == DRAW) ? ny_c : cur_y;
        in_scr_c   = (AW'(pix_x_c) < AW'(SCREEN_W)) && (AW'(pix_y_c) < AW'(SCREEN_H));
        pix_addr_c = AW'(pix_y_c) * AW'(SCREEN_W) + AW'(pix_x_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            raster_ready <= 1'b1;
            fb_wr_en     <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            seg_done     <= 1'b0;
            oob_flag     <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            color_q      <= '0;
            dx           <= '0;
            dy           <= '0;
            sx_neg       <= 1'b0;
            sy_neg       <= 1'b0;
            err          <= '0;
        end else begin
            seg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seg_vld) begin
                        cur_x        <= seg_x0;
                        cur_y        <= seg_y0;
                        x1_q         <= seg_x1;
                        y1_q         <= seg_y1;
                        color_q      <= seg_color;
                        raster_ready <= 1'b0;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    dx       <= dx_c;
                    dy       <= dy_c;
                    sx_neg   <= x1_q < cur_x;
                    sy_neg   <= y1_q < cur_y;
                    err      <= $signed(EW'(dx_c)) - $signed(EW'(dy_c));
                    fb_wr_en <= in_scr_c;
                    fb_addr  <= pix_addr_c;
                    fb_data  <= color_q;
                    if (!in_scr_c) oob_flag <= 1'b1;
                    state    <= DRAW;
                end
                DRAW: begin
                    if (advance_c) begin
                        if (at_end_c) begin
                            fb_wr_en <= 1'b0;
                            seg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cur_x    <= nx_c;
                            cur_y    <= ny_c;
                            err      <= nerr_c;
                            fb_wr_en <= in_scr_c;
                            fb_addr  <= pix_addr_c;
                            if (!in_scr_c) oob_flag <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    raster_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
